// File: rtl/collective_pkg.sv
// Shared definitions for the collective units: flit field layout, opcodes and child-mask indices.
package collective_pkg;

    localparam int PayloadWidthDefault = 32;
    localparam int HeaderWidth         = 50;
    localparam int FlitWidth           = PayloadWidthDefault + HeaderWidth;

    // Field offsets above the payload; absolute position = PayloadWidth + offset.
    localparam int OpOff    = 0;
    localparam int AlgOff   = 3;
    localparam int TagOff   = 6;
    localparam int CtxOff   = 14;
    localparam int RankOff  = 22;
    localparam int DstOff   = 31;
    localparam int SrcOff   = 40;
    localparam int ValidOff = 49;

    localparam int OpWidth    = 3;
    localparam int AlgWidth   = 3;
    localparam int TagWidth   = 8;
    localparam int CtxWidth   = 8;
    localparam int CoordWidth = 9;

    localparam int opPos       = PayloadWidthDefault + OpOff;
    localparam int algPos      = PayloadWidthDefault + AlgOff;
    localparam int tagPos      = PayloadWidthDefault + TagOff;
    localparam int ctxPos      = PayloadWidthDefault + CtxOff;
    localparam int rankPos     = PayloadWidthDefault + RankOff;
    localparam int dstPos      = PayloadWidthDefault + DstOff;
    localparam int srcPos      = PayloadWidthDefault + SrcOff;
    localparam int ValidBitPos = PayloadWidthDefault + ValidOff;

    typedef enum logic [2:0] {
        ShortBcast = 3'd0,
        LargeBcast = 3'd1,
        Scatter    = 3'd2,
        Allreduce  = 3'd3,
        Reduce     = 3'd4,
        Gather     = 3'd5
    } opcode_e;

    typedef enum logic [2:0] {
        ChildLocal = 3'd0,
        ChildPosX  = 3'd1,
        ChildNegX  = 3'd2,
        ChildPosY  = 3'd3,
        ChildNegY  = 3'd4,
        ChildPosZ  = 3'd5,
        ChildNegZ  = 3'd6
    } child_e;

    localparam int ChildCount = 7;

    typedef enum logic {IDLE, EMIT} state_e;

    function automatic logic [2:0] lowest_child(input logic [ChildCount-1:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = ChildCount - 1; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/torus_neighbor.sv
// Neighbour coordinate of a torus node in a given child direction, with wrap-around.
module torus_neighbor
    import collective_pkg::*;
#(
    parameter int DimX = 8,
    parameter int DimY = 8,
    parameter int DimZ = 8
) (
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic [2:0] z,
    input  logic [2:0] dir,
    output logic [2:0] nx,
    output logic [2:0] ny,
    output logic [2:0] nz
);

    function automatic logic [2:0] step_up(input logic [2:0] c, input int dim);
        return (c == 3'(dim - 1)) ? 3'd0 : c + 3'd1;
    endfunction

    function automatic logic [2:0] step_down(input logic [2:0] c, input int dim);
        return (c == 3'd0) ? 3'(dim - 1) : c - 3'd1;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        nx = x;
        ny = y;
        nz = z;
        case (child_e'(dir))
            ChildPosX: nx = step_up(x, DimX);
            ChildNegX: nx = step_down(x, DimX);
            ChildPosY: ny = step_up(y, DimY);
            ChildNegY: ny = step_down(y, DimY);
            ChildPosZ: nz = step_up(z, DimZ);
            ChildNegZ: nz = step_down(z, DimZ);
            default: ;
        endcase
    end

endmodule

// File: rtl/mcast_replicator.sv
// Emits one rewritten copy of each collective flit per child in the torus spanning tree.
// Optional duplicate-packet suppression is built when MCAST_DEDUP_EN is defined.
module mcast_replicator
    import collective_pkg::*;
#(
    parameter logic [2:0] rank_x       = 3'b0,
    parameter logic [2:0] rank_y       = 3'b0,
    parameter logic [2:0] rank_z       = 3'b0,
    parameter int         DimX         = 8,
    parameter int         DimY         = 8,
    parameter int         DimZ         = 8,
    parameter int         PayloadWidth = 32,
    parameter int         MaskWidth    = 7
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [PayloadWidth+HeaderWidth+MaskWidth-1:0] packet_in,
    input  logic                                       buf_empty,
    output logic                                       rd_en,
    input  logic                                       out_ready,
    output logic                                       valid_out,
    output logic [PayloadWidth+HeaderWidth-1:0]        Outpacket,
    output logic                                       done,
    output logic                                       busy
);

    localparam int FlitBits = PayloadWidth + HeaderWidth;
    localparam int ValidPos = PayloadWidth + ValidOff;
    localparam int SrcPos   = PayloadWidth + SrcOff;
    localparam int DstPos   = PayloadWidth + DstOff;
    localparam int CtxPos   = PayloadWidth + CtxOff;
    localparam int TagPos   = PayloadWidth + TagOff;

    state_e                state, state_next;
    logic [FlitBits-1:0]   pkt_reg, pkt_next;
    logic [MaskWidth-1:0]  mask_reg, mask_next, mask_rest;
    logic [FlitBits-1:0]   in_flit;
    logic [MaskWidth-1:0]  in_mask;
    logic                  accept, last_accept, load_ok, is_dup;
    logic [2:0]            child, nx, ny, nz;

    assign in_flit     = packet_in[FlitBits-1:0];
    assign in_mask     = packet_in[FlitBits +: MaskWidth];
    assign mask_rest   = mask_reg & (mask_reg - MaskWidth'(1));
    assign accept      = (state == EMIT) && out_ready;
    assign last_accept = accept && (mask_rest == '0);
    assign child       = lowest_child(mask_reg);

    assign rd_en     = ((state == IDLE) || last_accept) && !buf_empty && rst;
    assign valid_out = (state == EMIT);
    assign busy      = (state == EMIT);
    assign done      = last_accept;

`ifdef MCAST_DEDUP_EN
    logic [CtxWidth+TagWidth+CoordWidth-1:0] seen_key, in_key;
    logic                                    seen_valid;

    assign in_key = {in_flit[CtxPos +: CtxWidth], in_flit[TagPos +: TagWidth],
                     in_flit[SrcPos +: CoordWidth]};
    assign is_dup = seen_valid && (seen_key == in_key);

    always_ff @(posedge clk) begin
        if (!rst) begin
            seen_valid <= 1'b0;
            seen_key   <= '0;
        end else if (rd_en && load_ok) begin
            seen_valid <= 1'b1;
            seen_key   <= in_key;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    assign load_ok = in_flit[ValidPos] && (in_mask != '0) && !is_dup;

    torus_neighbor #(.DimX(DimX), .DimY(DimY), .DimZ(DimZ)) u_neighbor (
        .x   (rank_x),
        .y   (rank_y),
        .z   (rank_z),
        .dir (child),
        .nx  (nx),
        .ny  (ny),
        .nz  (nz)
    );

    // A pop on the last accepted copy overrides the return to IDLE: no bubble between packets.
    always_comb begin
        state_next = state;
        pkt_next   = pkt_reg;
        mask_next  = mask_reg;
        if (accept) begin
            mask_next = mask_rest;
            if (last_accept) state_next = IDLE;
        end
        if (rd_en) begin
            pkt_next   = in_flit;
            mask_next  = in_mask;
            state_next = load_ok ? EMIT : IDLE;
        end
    end

    always_comb begin
        Outpacket = '0;
        if (state == EMIT) begin
            Outpacket                          = pkt_reg;
            Outpacket[ValidPos]                = 1'b1;
            Outpacket[SrcPos +: CoordWidth]    = {rank_z, rank_y, rank_x};
            Outpacket[DstPos +: CoordWidth]    = {nz, ny, nx};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            mask_reg <= '0;
            pkt_reg  <= '0;
        end else begin
            state    <= state_next;
            mask_reg <= mask_next;
            pkt_reg  <= pkt_next;
        end
    end

endmodule

// File: tb/tb_mcast_replicator.sv
// Randomized bench for mcast_replicator against a copy-list reference model; honours MCAST_DEDUP_EN.
module tb_mcast_replicator;

    localparam logic [2:0] RX = 3'd7;
    localparam logic [2:0] RY = 3'd0;
    localparam logic [2:0] RZ = 3'd7;
    localparam int DX = 8;
    localparam int DY = 2;
    localparam int DZ = 8;
    localparam int PW = 32;
    localparam int FW = PW + 50;
    localparam int MW = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [FW+MW-1:0]  packet_in = '0;
    logic              buf_empty = 1'b1;
    logic              rd_en;
    logic              out_ready = 1'b0;
    logic              valid_out;
    logic [FW-1:0]     Outpacket;
    logic              done;
    logic              busy;

    always #5 clk = ~clk;

    mcast_replicator #(
        .rank_x(RX), .rank_y(RY), .rank_z(RZ),
        .DimX(DX), .DimY(DY), .DimZ(DZ),
        .PayloadWidth(PW), .MaskWidth(MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .packet_in (packet_in),
        .buf_empty (buf_empty),
        .rd_en     (rd_en),
        .out_ready (out_ready),
        .valid_out (valid_out),
        .Outpacket (Outpacket),
        .done      (done),
        .busy      (busy)
    );

    typedef struct {
        logic [FW-1:0] flit;
        logic [MW-1:0] mask;
    } entry_t;

    entry_t        fifo_q[$];
    logic [FW-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [24:0]   seen_key = '0;
    bit            seen_valid = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Layout MSB..LSB: valid, src, dst, rank, ctx, tag, algtype, op, payload.
    function automatic logic [FW-1:0] mk(input logic v, input logic [7:0] ctx, input logic [7:0] tag,
                                         input logic [8:0] src, input logic [8:0] rank,
                                         input logic [8:0] dst, input logic [2:0] op,
                                         input logic [2:0] alg, input logic [31:0] pay);
        return {v, src, dst, rank, ctx, tag, alg, op, pay};
    endfunction

    function automatic logic [8:0] dst_of(input int dir);
        int x, y, z;
        x = RX; y = RY; z = RZ;
        case (dir)
            1: x = (x + 1) % DX;
            2: x = (x + DX - 1) % DX;
            3: y = (y + 1) % DY;
            4: y = (y + DY - 1) % DY;
            5: z = (z + 1) % DZ;
            6: z = (z + DZ - 1) % DZ;
            default: ;
        endcase
        return {3'(z), 3'(y), 3'(x)};
    endfunction

    task automatic model_load(input entry_t e);
        logic [24:0] key;
        bit          dup;
        key = {e.flit[53:46], e.flit[45:38], e.flit[80:72]};
        dup = 1'b0;
`ifdef MCAST_DEDUP_EN
        dup = seen_valid && (seen_key == key);
`endif
        if (e.flit[81] && e.mask != '0 && !dup) begin
            seen_valid = 1'b1;
            seen_key   = key;
            for (int d = 0; d < MW; d++) begin
                if (e.mask[d]) exp_q.push_back({1'b1, RZ, RY, RX, dst_of(d), e.flit[62:0]});
            end
        end
    endtask

    task automatic push(input logic [FW-1:0] flit, input logic [MW-1:0] mask);
        entry_t e;
        e.flit = flit;
        e.mask = mask;
        fifo_q.push_back(e);
    endtask

    task automatic step(input logic rst_v, input logic rdy);
        bit exp_valid, exp_last, exp_rd;
        entry_t head;
        @(negedge clk);
        rst       = rst_v;
        out_ready = rdy;
        buf_empty = (fifo_q.size() == 0);
        packet_in = buf_empty ? '0 : {fifo_q[0].mask, fifo_q[0].flit};
        #1;
        exp_valid = exp_q.size() > 0;
        exp_last  = (exp_q.size() == 1) && rdy;
        exp_rd    = rst_v && (fifo_q.size() > 0) && (!exp_valid || exp_last);
        check("valid_out", valid_out, exp_valid);
        check("busy", busy, exp_valid);
        check("done", done, exp_last);
        check("rd_en", rd_en, exp_rd);
        if (exp_valid) check("Outpacket", Outpacket, exp_q[0]);
        else           check("Outpacket_idle", Outpacket, '0);
        if (!rst_v) begin
            exp_q.delete();
            seen_valid = 1'b0;
        end else begin
            if (exp_valid && rdy) void'(exp_q.pop_front());
            if (exp_rd) begin
                head = fifo_q.pop_front();
                model_load(head);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) step(1'b1, 1'b1);
        check("drain_timeout", 32'(fifo_q.size() + exp_q.size()), 0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0);
        push(mk(1'b1, 8'h02, 8'h05, 9'h000, 9'h000, 9'h000, 3'd0, 3'd0, 32'h3F80_0000), 7'b0000011);
        step(1'b0, 1'b1);

        // First-copy latency, priority order and wrap-around destinations.
        push(mk(1'b1, 8'h03, 8'h10, 9'h0AB, 9'h011, 9'h1FF, 3'd1, 3'd2, 32'hDEAD_BEEF), 7'b1000110);
        drain();

        // Size-2 Y dimension: both +y and -y emitted.
        push(mk(1'b1, 8'h04, 8'h11, 9'h001, 9'h000, 9'h000, 3'd2, 3'd0, 32'h1234_5678), 7'b0011000);
        drain();

        // Backpressure mid-packet with another entry waiting.
        push(mk(1'b1, 8'h05, 8'h20, 9'h002, 9'h003, 9'h004, 3'd3, 3'd1, 32'hCAFE_0001), 7'b0111100);
        push(mk(1'b1, 8'h06, 8'h21, 9'h005, 9'h006, 9'h007, 3'd4, 3'd1, 32'hCAFE_0002), 7'b0000001);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        drain();

        // Back-to-back single-copy packets.
        push(mk(1'b1, 8'h07, 8'h30, 9'h008, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0000_0001), 7'b0000001);
        push(mk(1'b1, 8'h08, 8'h31, 9'h009, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0000_0002), 7'b0000100);
        drain();

        // Discards: empty mask, then invalid flit.
        push(mk(1'b1, 8'h09, 8'h40, 9'h00A, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0000_0003), 7'b0000000);
        push(mk(1'b0, 8'h0A, 8'h41, 9'h00B, 9'h000, 9'h000, 3'd0, 3'd0, 32'h0000_0004), 7'b0000011);
        drain();

        // Reset with three copies pending; waiting FIFO head served afterwards.
        push(mk(1'b1, 8'h0B, 8'h50, 9'h00C, 9'h000, 9'h000, 3'd5, 3'd0, 32'h0000_0005), 7'b0101010);
        push(mk(1'b1, 8'h0C, 8'h51, 9'h00D, 9'h000, 9'h000, 3'd5, 3'd0, 32'h0000_0006), 7'b1000001);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        drain();

        // Identical packet twice: second suppressed only when dedup is built in.
        push(mk(1'b1, 8'h01, 8'h05, 9'h000, 9'h000, 9'h000, 3'd0, 3'd0, 32'h3F80_0000), 7'b0000011);
        push(mk(1'b1, 8'h01, 8'h05, 9'h000, 9'h000, 9'h000, 3'd0, 3'd0, 32'h3F80_0000), 7'b0000011);
        drain();

        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (fifo_q.size() < 4 && ($urandom % 3) == 0) begin
                push(mk(($urandom % 8) != 0, 8'($urandom % 4), 8'($urandom % 4), 9'($urandom % 2),
                        9'($urandom), 9'($urandom), 3'($urandom), 3'($urandom), $urandom),
                     (($urandom % 6) == 0) ? 7'd0 : 7'($urandom));
            end
            step(($urandom % 200) != 0, ($urandom % 4) != 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
